// File: rtl/cla_sum_pipe.sv
// Three-stage pipelined carry-lookahead sum stage with valid/ready flow control.
// Optional: define CLA_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module cla_sum_pipe #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] t,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  logic stall;
  logic accept;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g, s1_p, s1_t;
  logic             s1_cin;
  logic [NG-1:0]    s1_gg, s1_gp;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_g, s2_p, s2_t;
  logic [NG:0]      s2_gc;

  logic [NG-1:0]    grp_g_d, grp_p_d;
  logic [NG:0]      grp_c_d;
  logic [WIDTH-1:0] sum_d;
  logic             msb_c_d;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Group generate/propagate, folded from the lowest bit of each group upward
  always_comb begin
    logic gacc, pacc;
    gacc    = 1'b0;
    pacc    = 1'b1;
    grp_g_d = '0;
    grp_p_d = '0;
    for (int j = 0; j < NG; j++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int k = 0; k < GROUP; k++) begin
        gacc = g[j*GROUP+k] | (p[j*GROUP+k] & gacc);
        pacc = pacc & p[j*GROUP+k];
      end
      grp_g_d[j] = gacc;
      grp_p_d[j] = pacc;
    end
  end

  // Lookahead across groups; entry NG is the carry out of the whole word
  always_comb begin
    logic cacc;
    cacc    = s1_cin;
    grp_c_d = '0;
    for (int j = 0; j < NG; j++) begin
      grp_c_d[j] = cacc;
      cacc       = s1_gg[j] | (s1_gp[j] & cacc);
    end
    grp_c_d[NG] = cacc;
  end

  // Per-bit carries restart from each group's lookahead carry
  always_comb begin
    logic cacc;
    cacc    = 1'b0;
    msb_c_d = 1'b0;
    sum_d   = '0;
    for (int j = 0; j < NG; j++) begin
      cacc = s2_gc[j];
      for (int k = 0; k < GROUP; k++) begin
        sum_d[j*GROUP+k] = s2_t[j*GROUP+k] ^ cacc;
        if (j*GROUP+k == WIDTH-1) msb_c_d = cacc;
        cacc = s2_g[j*GROUP+k] | (s2_p[j*GROUP+k] & cacc);
      end
    end
  end

  // All stages advance together unless the output is held by the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else if (!stall) begin
      s1_valid  <= accept;
      s1_g      <= g;
      s1_p      <= p;
      s1_t      <= t;
      s1_cin    <= cin;
      s1_gg     <= grp_g_d;
      s1_gp     <= grp_p_d;
      s2_valid  <= s1_valid;
      s2_g      <= s1_g;
      s2_p      <= s1_p;
      s2_t      <= s1_t;
      s2_gc     <= grp_c_d;
      out_valid <= s2_valid;
      sum       <= sum_d;
      cout      <= s2_gc[NG];
`ifdef CLA_OVF_FLAG_EN
      ovf       <= s2_gc[NG] ^ msb_c_d;
`endif
    end
  end

`ifndef CLA_OVF_FLAG_EN
  logic unused_msb;
  assign unused_msb = msb_c_d;
`endif

endmodule

// File: tb/tb_cla_sum_pipe.sv
// Directed-vector and scoreboard bench for cla_sum_pipe (64-bit default build).
module tb_cla_sum_pipe;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] g, p, t;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_FLAG_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  vec_t vecs[10];
  res_t sb_q[$];

  always #5 clk = ~clk;

  cla_sum_pipe #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .g(g),
    .p(p),
    .t(t),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
`ifdef CLA_OVF_FLAG_EN
    ,
    .ovf(ovf)
`endif
  );

  function automatic res_t refModel(input logic [63:0] a, input logic [63:0] b, input logic ci);
    res_t r;
    logic [64:0] full;
    logic [63:0] low;
    full   = {1'b0, a} + {1'b0, b} + {64'b0, ci};
    low    = {1'b0, a[62:0]} + {1'b0, b[62:0]} + {63'b0, ci};
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = full[64] ^ low[63];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One clock: drive at the falling edge, score the handshake, advance to the next falling edge
  task automatic applyStimulus(input logic r, input logic iv, input logic [63:0] a,
                               input logic [63:0] b, input logic ci, input logic ordy);
    res_t want;
    rst       = r;
    in_valid  = iv;
    g         = a & b;
    p         = a | b;
    t         = a ^ b;
    cin       = ci;
    out_ready = ordy;
    #1;
    if (!r) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_result", {63'b0, out_valid}, 64'd0);
        end else begin
          want = sb_q.pop_front();
          checkOutput("sb_sum", sum, want.sum);
          checkOutput("sb_cout", {63'b0, cout}, {63'b0, want.cout});
`ifdef CLA_OVF_FLAG_EN
          checkOutput("sb_ovf", {63'b0, ovf}, {63'b0, want.ovf});
`endif
        end
      end
      if (in_valid && in_ready) sb_q.push_back(refModel(a, b, ci));
    end
    @(posedge clk);
    if (r) sb_q.delete();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] snap_sum;
    logic        snap_cout;
    logic [63:0] av, bv;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[3] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[8] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[9] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; g = '0; p = '0; t = '0; cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_sum", sum, 64'd0);
    checkOutput("rst_cout", {63'b0, cout}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
`ifdef CLA_OVF_FLAG_EN
    checkOutput("rst_ovf", {63'b0, ovf}, 64'd0);
`endif

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      checkOutput("lat_cycle1", {63'b0, out_valid}, 64'd0);
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      checkOutput("lat_cycle2", {63'b0, out_valid}, 64'd0);
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      checkOutput("vec_valid", {63'b0, out_valid}, 64'd1);
      checkOutput("vec_sum", sum, vecs[i].exp_sum);
      checkOutput("vec_cout", {63'b0, cout}, {63'b0, vecs[i].exp_cout});
`ifdef CLA_OVF_FLAG_EN
      checkOutput("vec_ovf", {63'b0, ovf}, {63'b0, vecs[i].exp_ovf});
`endif
    end
    drain(4);

    $display("[TB] back-to-back");
    for (int c = 0; c < 12; c++) begin
      av = 64'h1111_1111_1111_1111 * 64'(c);
      bv = 64'hF0F0_F0F0_F0F0_F0F0 ^ 64'(c);
      checkOutput("b2b_valid", {63'b0, out_valid}, {63'b0, (c >= 3 && c <= 10)});
      if (c < 8) checkOutput("b2b_in_ready", {63'b0, in_ready}, 64'd1);
      applyStimulus(1'b0, c < 8, av, bv, 1'(c % 2), 1'b1);
    end
    checkOutput("b2b_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] stall");
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'(c), 1'b0);
    checkOutput("stall_valid", {63'b0, out_valid}, 64'd1);
    snap_sum  = sum;
    snap_cout = cout;
    for (int s = 0; s < 5; s++) begin
      checkOutput("stall_in_ready", {63'b0, in_ready}, 64'd0);
      checkOutput("stall_sum_held", sum, snap_sum);
      checkOutput("stall_cout_held", {63'b0, cout}, {63'b0, snap_cout});
      applyStimulus(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h1234, 1'b1, 1'b0);
    end
    drain(6);
    checkOutput("stall_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] reset in flight");
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 1'b1, 64'h100 + 64'(c), 64'h200, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'h5, 64'h6, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("midrst_sum", sum, 64'd0);
    checkOutput("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      checkOutput("midrst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    drain(8);
    checkOutput("random_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
